// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
//
// Pipeline controller for the 5-stage RV32 core. It sits beside the datapath,
// reads register fields from the D/E/M/W stages and produces the stall/flush
// controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also produces
// the operand forwarding selects and runs a small FSM that holds the whole
// pipeline while a data-memory access in M is outstanding.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   : stall_cycles / flush_count performance counters are built
//   undefined : no counter flops, both counter ports read 0
//
// Parameters
//   LOAD_SRC   ResultSrcE encoding that marks a load in E
//   TIMEOUT    MEM_WAIT cycles before mem_timeout is raised (1..255)
//   CNT_W      width of the performance counters
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   Rs1D, Rs2D              source registers of the instruction in D
//   Rs1E, Rs2E              source registers of the instruction in E
//   RdE, RdM, RdW           destination registers in E / M / W
//   ResultSrcE              result select of the instruction in E
//   RegWriteM, RegWriteW    register write enables in M / W
//   PCSrcE                  taken branch/jump resolved in E
//   dmem_req_M              M-stage load/store issues a memory request
//   dmem_ready              memory completes the M-stage access this cycle
//   StallF, StallD          hold PC / IF-ID register
//   StallE, StallM          hold ID-EX / EX-MEM register
//   FlushD, FlushE          synchronous clear of IF-ID / ID-EX
//   FlushW                  bubble into MEM-WB
//   ForwardAE, ForwardBE    00 regfile, 10 from M, 01 from W
//   mem_timeout             sticky: memory wait reached TIMEOUT cycles
//   stall_cycles            cycles with StallF or StallE high
//   flush_count             cycles with FlushE high
// -----------------------------------------------------------------------------
module hazard_ctrl_unit #(
    parameter logic [2:0]  LOAD_SRC = 3'b001,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [2:0]       ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             dmem_req_M,
    input  logic             dmem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_timeout_q, mem_timeout_d;
    logic       lw_stall;
    logic       mem_stall;

    // M has priority over W: M holds the younger, more recent value.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       reg_write_m,
        input logic [4:0] rd_m,
        input logic       reg_write_w,
        input logic [4:0] rd_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
    assign ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);

    // Hazard detection and stall/flush outputs
    always_comb begin
        lw_stall = (ResultSrcE == LOAD_SRC) && (RdE != 5'd0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D));

        // In RUN a new request without ready stalls at once (no added
        // latency); in MEM_WAIT only ready releases the pipeline.
        if (state_q == RUN) begin
            mem_stall = dmem_req_M && !dmem_ready;
        end else begin
            mem_stall = !dmem_ready;
        end

        StallF = lw_stall;
        StallD = lw_stall;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = PCSrcE;
        FlushE = lw_stall || PCSrcE;
        FlushW = 1'b0;

        // A memory wait freezes everything, including a resolved branch in E;
        // the branch keeps PCSrcE asserted and flushes once the wait ends.
        if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushD = 1'b0;
            FlushE = 1'b0;
            FlushW = 1'b1;
        end
    end

    // Memory wait FSM, wait counter and sticky timeout
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            RUN: begin
                if (dmem_req_M && !dmem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd0;
                end
            end
            MEM_WAIT: begin
                if (wait_cnt_q != TIMEOUT_C) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
                // Diagnostic only: the access is never aborted.
                if (wait_cnt_d == TIMEOUT_C) begin
                    mem_timeout_d = 1'b1;
                end
                if (dmem_ready) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    // Performance counters, wrapping modulo 2^CNT_W
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, (StallF || StallE)};
        flush_count_d  = flush_count_q + {{(CNT_W-1){1'b0}}, FlushE};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl_unit
//
// Directed bench for hazard_ctrl_unit (built with TIMEOUT=4). A behavioural
// model derives every output from the pipeline rules each cycle and a single
// compare process checks the DUT against it on the falling edge; the directed
// sequences add hand-computed literal expectations that pin the model.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

    localparam int CNT_W = 32;
    localparam int TMO   = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [4:0]       Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0;
    logic [4:0]       RdE = '0, RdM = '0, RdW = '0;
    logic [2:0]       ResultSrcE = '0;
    logic             RegWriteM = 1'b0, RegWriteW = 1'b0, PCSrcE = 1'b0;
    logic             dmem_req_M = 1'b0, dmem_ready = 1'b0;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    hazard_ctrl_unit #(
        .LOAD_SRC (3'b001),
        .TIMEOUT  (TMO),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Rs1D         (Rs1D),
        .Rs2D         (Rs2D),
        .Rs1E         (Rs1E),
        .Rs2E         (Rs2E),
        .RdE          (RdE),
        .RdM          (RdM),
        .RdW          (RdW),
        .ResultSrcE   (ResultSrcE),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .PCSrcE       (PCSrcE),
        .dmem_req_M   (dmem_req_M),
        .dmem_ready   (dmem_ready),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushW       (FlushW),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit m_waiting   = 1'b0;   // a memory access is outstanding
    int m_wait_len  = 0;      // cycles spent waiting since entry
    bit m_timeout   = 1'b0;
    int m_stall_cnt = 0;
    int m_flush_cnt = 0;

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 5'd0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    function automatic logic [6:0] exp_ctrl();
        logic lw;
        logic ms;
        lw = (ResultSrcE == 3'b001) && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
        ms = !dmem_ready && (m_waiting || dmem_req_M);
        if (ms) return 7'b1111001;
        return {lw, lw, 1'b0, 1'b0, PCSrcE, lw | PCSrcE, 1'b0};
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [6:0] e;
        if (reset) begin
            m_waiting   <= 1'b0;
            m_wait_len  <= 0;
            m_timeout   <= 1'b0;
            m_stall_cnt <= 0;
            m_flush_cnt <= 0;
        end else begin
            e = exp_ctrl();
            if (!m_waiting) begin
                if (dmem_req_M && !dmem_ready) begin
                    m_waiting  <= 1'b1;
                    m_wait_len <= 0;
                end
            end else begin
                m_wait_len <= m_wait_len + 1;
                if (m_wait_len + 1 >= TMO) m_timeout <= 1'b1;
                if (dmem_ready) m_waiting <= 1'b0;
            end
`ifdef HAZARD_PERF_CNT_EN
            if (e[6] || e[4]) m_stall_cnt <= m_stall_cnt + 1;
            if (e[1]) m_flush_cnt <= m_flush_cnt + 1;
`endif
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ctrl", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, 32'(exp_ctrl()));
            chk("fwdA", 32'(ForwardAE), 32'(exp_fwd(Rs1E)));
            chk("fwdB", 32'(ForwardBE), 32'(exp_fwd(Rs2E)));
            chk("timeout", 32'(mem_timeout), 32'(m_timeout));
            chk("stall_cycles", stall_cycles, m_stall_cnt);
            chk("flush_count", flush_count, m_flush_cnt);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
        dmem_req_M = 0; dmem_ready = 0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        #2 reset = 1'b1;
        #1 cmp_en = 1'b1;
        settle();
        chk("rst_stallF", StallF, 0);
        chk("rst_timeout", mem_timeout, 0);
        chk("rst_stall_cycles", stall_cycles, 0);
        adv();
        reset = 1'b0;

        // 1: lw x5 in E, add x6,x5,x1 in D
        ResultSrcE = 3'b001; RdE = 5; Rs1D = 5; Rs2D = 1;
        settle();
        chk("lw_stallF", StallF, 1);
        chk("lw_stallD", StallD, 1);
        chk("lw_flushE", FlushE, 1);
        chk("lw_flushD", FlushD, 0);
        adv();
        // bubble in E, lw in M, add still in D
        ResultSrcE = 0; RdE = 0; RegWriteM = 1; RdM = 5;
        settle();
        chk("lw_release", StallF, 0);
        adv();
        // add in E, lw in W
        Rs1D = 0; Rs2D = 0; Rs1E = 5; Rs2E = 1;
        RegWriteM = 0; RdM = 0; RegWriteW = 1; RdW = 5;
        settle();
        chk("lw_fwdA_W", ForwardAE, 2'b01);
        chk("lw_fwdB", ForwardBE, 2'b00);
        adv();

        // 2: forwarding priority
        idle();
        RegWriteM = 1; RdM = 7; RegWriteW = 1; RdW = 7; Rs1E = 7; Rs2E = 7;
        settle();
        chk("fwd_M_prio", ForwardAE, 2'b10);
        chk("fwd_M_prioB", ForwardBE, 2'b10);
        adv();
        RdM = 0; RegWriteW = 0;
        settle();
        chk("fwd_rd0", ForwardAE, 2'b00);
        adv();
        RegWriteW = 1;
        settle();
        chk("fwd_rd0_W", ForwardAE, 2'b01);
        adv();

        // 3: taken branch
        idle();
        PCSrcE = 1;
        settle();
        chk("br_flushD", FlushD, 1);
        chk("br_flushE", FlushE, 1);
        chk("br_stallF", StallF, 0);
        adv();
        PCSrcE = 0;
        settle();
        chk("br_once", FlushE, 0);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall", stall_cycles, 1);
        chk("perf_flush", flush_count, 2);
`else
        chk("perf_stall_off", stall_cycles, 0);
        chk("perf_flush_off", flush_count, 0);
`endif
        adv();

        // lw-use and branch together; load with rd=x0; non-load in E
        ResultSrcE = 3'b001; RdE = 9; Rs2D = 9; PCSrcE = 1;
        settle();
        chk("lwbr_flushD", FlushD, 1);
        chk("lwbr_stallF", StallF, 1);
        adv();
        idle();
        ResultSrcE = 3'b001; RdE = 0; Rs1D = 0;
        settle();
        chk("lw_x0", StallF, 0);
        adv();
        ResultSrcE = 3'b010; RdE = 4; Rs1D = 4;
        settle();
        chk("nonload", StallF, 0);
        adv();

        // zero-cycle access
        idle();
        dmem_req_M = 1; dmem_ready = 1;
        settle();
        chk("zc_stall", StallM, 0);
        adv();
        dmem_req_M = 0; dmem_ready = 0;
        settle();
        chk("zc_run", StallF, 0);
        adv();

        // 4: three wait cycles with a branch held in E
        dmem_req_M = 1; dmem_ready = 0; PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("mw_stallF", StallF, 1);
            chk("mw_stallM", StallM, 1);
            chk("mw_flushW", FlushW, 1);
            chk("mw_flushE", FlushE, 0);
            adv();
        end
        dmem_ready = 1;
        settle();
        chk("mw_done_stallE", StallE, 0);
        chk("mw_done_flushE", FlushE, 1);
        adv();
        idle();
        settle();
        chk("mw_run", StallF, 0);
        chk("mw_no_tmo", mem_timeout, 0);
        adv();

        // 5: timeout with ready low for 6 cycles
        dmem_req_M = 1; dmem_ready = 0;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("to_stall", StallD, 1);
            if (i == 4) chk("to_not_yet", mem_timeout, 0);
            if (i == 5) chk("to_raised", mem_timeout, 1);
            adv();
        end
        dmem_ready = 1;
        settle();
        chk("to_release", StallF, 0);
        adv();
        idle();
        settle();
        chk("to_sticky", mem_timeout, 1);
        adv();
        dmem_req_M = 1;
        settle();
        adv();
        dmem_req_M = 0;
        settle();
        chk("rw_waiting", StallF, 1);
        adv();
        reset = 1'b1;
        #1;
        chk("rw_rst_tmo", mem_timeout, 0);
        chk("rw_rst_stall", StallF, 0);
        chk("rw_rst_cnt", flush_count, 0);
        settle();
        adv();
        reset = 1'b0;
        settle();
        chk("rw_run", StallE, 0);
        adv();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
